// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with clamped preset load, digit borrow and terminal-count pulse.
// Define BCD_DOWN_AUTORELOAD_EN to reload the preset at terminal count instead of stopping.
module bcd_down_counter #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  en,
    output logic [4*DIGITS-1:0]   q,
    output logic                  running,
    output logic                  done,
    output logic                  tc
);

    localparam int unsigned W = 4 * DIGITS;
    localparam logic [W-1:0] ONE = W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   q_q, q_d;
    logic           tc_q, tc_d;
`ifdef BCD_DOWN_AUTORELOAD_EN
    logic [W-1:0]   reload_q, reload_d;
`endif

    // Force any non-decimal digit to 9.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
        end
        return r;
    endfunction

    // Ripple-borrow decrement: a 0 digit becomes 9 and passes the borrow on.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            q_q      <= '0;
            tc_q     <= 1'b0;
`ifdef BCD_DOWN_AUTORELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            tc_q     <= tc_d;
`ifdef BCD_DOWN_AUTORELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    // Command priority: load, then start (outside RUN), then en (in RUN).
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        tc_d     = 1'b0;
`ifdef BCD_DOWN_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (load) begin
            q_d     = bcd_clamp(load_val);
            state_d = S_IDLE;
`ifdef BCD_DOWN_AUTORELOAD_EN
            reload_d = bcd_clamp(load_val);
`endif
        end else if (start && (state_q != S_RUN)) begin
            if (q_q != '0) begin
                state_d = S_RUN;
            end else begin
                state_d = S_DONE;
                tc_d    = 1'b1;
            end
        end else if ((state_q == S_RUN) && en) begin
            if (q_q == ONE) begin
`ifdef BCD_DOWN_AUTORELOAD_EN
                q_d     = reload_q;
`else
                q_d     = '0;
                state_d = S_DONE;
`endif
                tc_d    = 1'b1;
            end else if (q_q != '0) begin
                q_d = bcd_dec(q_q);
            end
        end
    end

    assign q       = q_q;
    assign tc      = tc_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: decimal reference model feeds an expectation queue
// that is popped and compared one cycle after each stimulus step.
module tb_bcd_down_counter;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    typedef struct packed {
        logic [W-1:0] q;
        logic         running;
        logic         done;
        logic         tc;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          load;
    logic [W-1:0]  load_val;
    logic          start;
    logic          en;
    logic [W-1:0]  q;
    logic          running;
    logic          done;
    logic          tc;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model kept as a plain decimal integer.
    int   m_val;
    int   m_reload;
    int   m_state;   // 0 idle, 1 run, 2 done
    logic m_tc;

    bcd_down_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .en       (en),
        .q        (q),
        .running  (running),
        .done     (done),
        .tc       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clamp_to_int(input logic [W-1:0] v);
        int val;
        int mul;
        int d;
        val = 0;
        mul = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            val = val + d * mul;
            mul = mul * 10;
        end
        return val;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = n;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.q       = int_to_bcd(m_val);
        e.running = (m_state == 1);
        e.done    = (m_state == 2);
        e.tc      = m_tc;
        return e;
    endfunction

    task automatic model_step(input logic l, input logic [W-1:0] lv, input logic s, input logic e);
        m_tc = 1'b0;
        if (l) begin
            m_val    = clamp_to_int(lv);
            m_reload = m_val;
            m_state  = 0;
        end else if (s && m_state != 1) begin
            if (m_val != 0) begin
                m_state = 1;
            end else begin
                m_state = 2;
                m_tc    = 1'b1;
            end
        end else if (m_state == 1 && e) begin
            if (m_val == 1) begin
`ifdef BCD_DOWN_AUTORELOAD_EN
                m_val   = m_reload;
`else
                m_val   = 0;
                m_state = 2;
`endif
                m_tc    = 1'b1;
            end else if (m_val > 0) begin
                m_val = m_val - 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_now(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".q"},       32'(q),       32'(e.q));
            chk({tag, ".running"}, 32'(running), 32'(e.running));
            chk({tag, ".done"},    32'(done),    32'(e.done));
            chk({tag, ".tc"},      32'(tc),      32'(e.tc));
        end
    endtask

    // Drive one cycle of stimulus, predict, clock, then compare just after the edge.
    task automatic step(input string tag, input logic l, input logic [W-1:0] lv,
                        input logic s, input logic e);
        load     = l;
        load_val = lv;
        start    = s;
        en       = e;
        model_step(l, lv, s, e);
        exp_q.push_back(model_exp());
        @(posedge clk);
        #1;
        compare_now(tag);
    endtask

    initial begin
        int         rnd_en;
        logic [W-1:0] held;
        reset_n  = 1'b0;
        load     = 1'b0;
        load_val = '0;
        start    = 1'b0;
        en       = 1'b0;
        m_val    = 0;
        m_reload = 0;
        m_state  = 0;
        m_tc     = 1'b0;

        #12;
        exp_q.push_back(model_exp());
        compare_now("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Clamp of non-decimal digits, then IDLE ignores en.
        step("clamp",     1'b1, 16'hA5F3, 1'b0, 1'b0);
        chk("clamp.q_lit", 32'(q), 32'h9593);
        step("idle_hold", 1'b0, 16'h0000, 1'b0, 1'b1);

        // Full borrow chain from 1000.
        step("bor_load",  1'b1, 16'h1000, 1'b0, 1'b0);
        step("bor_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        step("bor_dec",   1'b0, 16'h0000, 1'b0, 1'b1);
        chk("bor.q_lit", 32'(q), 32'h0999);

        // Start with zero count goes straight to DONE; start in DONE re-pulses tc.
        step("zero_load",  1'b1, 16'h0000, 1'b0, 1'b0);
        step("zero_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        chk("zero.tc_lit", 32'(tc), 32'h1);
        step("zero_hold",  1'b0, 16'h0000, 1'b0, 1'b1);
        step("zero_rest",  1'b0, 16'h0000, 1'b1, 1'b1);

        // 103 down to terminal with en held high.
        step("c103_load",  1'b1, 16'h0103, 1'b0, 1'b0);
        step("c103_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 103; i++) begin
            step($sformatf("c103_%0d", i), 1'b0, 16'h0000, 1'b0, 1'b1);
            if (i == 3) chk("c103.q_lit", 32'(q), 32'h0099);
        end
`ifndef BCD_DOWN_AUTORELOAD_EN
        chk("c103.done_lit", 32'(done), 32'h1);
`endif
        step("c103_post0", 1'b0, 16'h0000, 1'b0, 1'b1);
        step("c103_post1", 1'b0, 16'h0000, 1'b0, 1'b1);

        // Load with start while running: load wins, back to IDLE.
        step("pri_load",  1'b1, 16'h0030, 1'b0, 1'b0);
        step("pri_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        step("pri_dec",   1'b0, 16'h0000, 1'b0, 1'b1);
        step("pri_ls",    1'b1, 16'h0020, 1'b1, 1'b1);
        chk("pri.q_lit", 32'(q), 32'h0020);
        step("pri_idle",  1'b0, 16'h0000, 1'b0, 1'b1);

        // Start ignored in RUN; en toggling holds on en=0 cycles.
        step("tog_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        step("run_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 24; i++) begin
            rnd_en = int'($urandom_range(0, 1));
            held   = q;
            step($sformatf("tog_%0d", i), 1'b0, 16'h0000, 1'b0, rnd_en[0]);
            if (rnd_en == 0) chk($sformatf("tog_hold_%0d", i), 32'(q), 32'(held));
        end

        // Asynchronous reset in the middle of a count, checked before any clock edge.
        step("ar_load",  1'b1, 16'h0060, 1'b0, 1'b0);
        step("ar_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step($sformatf("ar_dec%0d", i), 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("ar.q_pre", 32'(q), 32'h0057);
        #1 reset_n = 1'b0;
        #1;
        m_val    = 0;
        m_reload = 0;
        m_state  = 0;
        m_tc     = 1'b0;
        exp_q.push_back(model_exp());
        compare_now("async_rst");
        reset_n = 1'b1;
        step("ar_after", 1'b0, 16'h0000, 1'b0, 1'b1);

`ifdef BCD_DOWN_AUTORELOAD_EN
        step("rl_load",  1'b1, 16'h0003, 1'b0, 1'b0);
        step("rl_start", 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step($sformatf("rl_%0d", i), 1'b0, 16'h0000, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
